// File: rtl/sd_err_pkg.sv
// Shared definitions for the SD host error interrupt block: error bit map,
// reserved-bit default, register offsets and first-error FSM state type.
package sd_err_pkg;

    // Error Interrupt Status bit positions
    localparam int CMD_TO     = 0;
    localparam int CMD_CRC    = 1;
    localparam int CMD_END    = 2;
    localparam int CMD_IDX    = 3;
    localparam int DAT_TO     = 4;
    localparam int DAT_CRC    = 5;
    localparam int DAT_END    = 6;
    localparam int CUR_LIM    = 7;
    localparam int ACMD12     = 8;
    localparam int ADMA       = 9;
    localparam int VENDOR_LSB = 12;

    localparam logic [15:0] RSVD_MASK_DFLT = 16'h0C00;

    // Register offsets seen by the bus decoder
    localparam logic [7:0] OFS_ERR_STAT    = 8'h32;
    localparam logic [7:0] OFS_ERR_STAT_EN = 8'h36;
    localparam logic [7:0] OFS_ERR_SIG_EN  = 8'h3A;

    typedef enum logic {
        FE_IDLE = 1'b0,
        FE_HELD = 1'b1
    } feState_e;

endpackage

// File: rtl/sd_err_int_ctrl_if.sv
// Register-bus side of the error interrupt block: byte-enabled write strobes
// from the decoder and the three register read-back values.
interface sd_err_int_ctrl_if #(
    parameter int WIDTH = 16
) ();

    logic [WIDTH/8-1:0] wr_be;
    logic               stat_wr;
    logic               stat_en_wr;
    logic               sig_en_wr;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH-1:0]   status;
    logic [WIDTH-1:0]   stat_en;
    logic [WIDTH-1:0]   sig_en;

    modport master (
        output wr_be, stat_wr, stat_en_wr, sig_en_wr, wdata,
        input  status, stat_en, sig_en
    );

    modport slave (
        input  wr_be, stat_wr, stat_en_wr, sig_en_wr, wdata,
        output status, stat_en, sig_en
    );

endinterface

// File: rtl/sd_w1c_bit.sv
// One sticky status bit: set wins over clear, reserved bits stay zero.
// qNext is exposed so the parent can see the value about to be loaded.
module sd_w1c_bit (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    input  logic rsvd,
    output logic q,
    output logic qNext
);

    assign qNext = ~rsvd & (set | (q & ~clr));

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else     q <= qNext;
    end

endmodule

// File: rtl/sd_err_int_ctrl.sv
// Error Interrupt Status / Status Enable / Signal Enable registers with
// masked interrupt, summary bit and first-error capture.
module sd_err_int_ctrl
    import sd_err_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RSVD_MASK = RSVD_MASK_DFLT,
    parameter int               IDX_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    err_evt,
    sd_err_int_ctrl_if.slave    regBus,
    output logic                err_irq,
    output logic                err_summary,
    output logic [IDX_W-1:0]    first_err_idx,
    output logic                first_err_vld
);

    logic [WIDTH-1:0] beMask;
    logic [WIDTH-1:0] setVec;
    logic [WIDTH-1:0] clrVec;
    logic [WIDTH-1:0] statusQ;
    logic [WIDTH-1:0] statusNext;
    logic [WIDTH-1:0] statEnQ;
    logic [WIDTH-1:0] sigEnQ;
    feState_e         state;
    feState_e         stateNext;

    function automatic logic [IDX_W-1:0] lowestSet(input logic [WIDTH-1:0] v);
        lowestSet = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) lowestSet = IDX_W'(i);
        end
    endfunction

    always_comb begin
        for (int i = 0; i < WIDTH; i++) beMask[i] = regBus.wr_be[i/8];
    end

    // Set uses the registered enable, so an enable write acts from the next cycle
    assign setVec = err_evt & statEnQ;
    assign clrVec = regBus.stat_wr ? (beMask & regBus.wdata) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            statEnQ <= '0;
            sigEnQ  <= '0;
        end else begin
            if (regBus.stat_en_wr)
                statEnQ <= ~RSVD_MASK & ((statEnQ & ~beMask) | (regBus.wdata & beMask));
            if (regBus.sig_en_wr)
                sigEnQ  <= ~RSVD_MASK & ((sigEnQ & ~beMask) | (regBus.wdata & beMask));
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gStat
        sd_w1c_bit uBit (
            .clk   (clk),
            .rst   (rst),
            .set   (setVec[i]),
            .clr   (clrVec[i]),
            .rsvd  (RSVD_MASK[i]),
            .q     (statusQ[i]),
            .qNext (statusNext[i])
        );
    end

    // First-error capture FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= FE_IDLE;
        else     state <= stateNext;
    end

    // NOTE: default assignment first so no path leaves stateNext unassigned (no latch).
    always_comb begin
        stateNext = state;
        unique case (state)
            FE_IDLE: if (statusQ == '0 && statusNext != '0) stateNext = FE_HELD;
            FE_HELD: if (statusNext == '0)                  stateNext = FE_IDLE;
        endcase
    end

    always_comb begin
        first_err_vld = (state == FE_HELD);
    end

    // Index is frozen outside the empty-to-nonempty transition, even back in IDLE
    always_ff @(posedge clk) begin
        if (rst)
            first_err_idx <= '0;
        else if (state == FE_IDLE && stateNext == FE_HELD)
            first_err_idx <= lowestSet(statusNext);
    end

    assign err_irq        = |(statusQ & sigEnQ);
    assign err_summary    = |statusQ;
    assign regBus.status  = statusQ;
    assign regBus.stat_en = statEnQ;
    assign regBus.sig_en  = sigEnQ;

endmodule
